interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
Interrupt source side of the CPU interrupt interface. It collects level requests from peripherals, masks and prioritises them, and drives the CPU's INT and NMI lines. It completes the handshake with the CPU's acknowledge and end-of-interrupt pulses. The block sits between the peripheral bus and the CPU core, and is instantiated next to the CPU in the top-level and CPU test fixtures.

Parameters:
N_SRC, 8, number of maskable request lines (2..32)
ID_W, 3, width of INT_ID; must equal ceil(log2(N_SRC))

Ports:
CLK  input  1  system clock; all state updates on the rising edge
RST  input  1  synchronous reset, active-high
IRQ  input  N_SRC  level-sensitive peripheral requests; bit 0 has the highest priority
NMI_IN  input  1  non-maskable request pin; a rising edge triggers it
MASK_WE  input  1  when 1, MASK_DATA is loaded into the mask register
MASK_DATA  input  N_SRC  mask value; bit = 1 enables that source
INT_FLAG  input  1  CPU global interrupt enable
INT_ACK  input  1  one-cycle pulse: the CPU has taken the interrupt currently signalled
EOI  input  1  one-cycle pulse: the CPU has finished the maskable handler
INT  output  1  maskable interrupt request to the CPU
NMI  output  1  non-maskable interrupt request to the CPU
INT_ID  output  ID_W  index of the latched or in-service source
IN_SERVICE  output  1  a maskable interrupt is being serviced

Behaviour:
- Reset values (RST=1 at an edge): INT=0, NMI=0, INT_ID=0, IN_SERVICE=0, mask=0 (all sources disabled), FSM=IDLE, nmi_pend=0, nmi_d=0. Reset overrides every other input, including reset during PEND or SERVICE.
- All outputs are registered.
- Mask write: at an edge with MASK_WE=1, the mask takes MASK_DATA. The new mask affects arbitration from the next edge.
- Request vector: req = IRQ & mask. Winner = lowest set index of req.
- Maskable FSM, 3 states:
  - IDLE: at an edge with INT_FLAG=1 and req!=0:
    - latch the winner into INT_ID
    - go to PEND
    - set INT=1 at the same edge (latency is 1 edge from a sampled request).
  - PEND:
    - INT_ID is frozen. A request that deasserts or is masked does not withdraw the interrupt.
    - INT = INT_FLAG, registered: if INT_FLAG is low at an edge, INT=0 after that edge and the FSM stays in PEND; INT re-asserts once INT_FLAG returns.
    - An edge with INT_ACK=1 and NMI=0 moves the FSM to SERVICE: INT=0, IN_SERVICE=1.
  - SERVICE:
    - No nesting: new requests are ignored.
    - An edge with EOI=1 moves the FSM to IDLE: IN_SERVICE=0. Re-arbitration happens at the following edge, so there is a minimum 1-cycle gap between EOI and the next INT.
    - EOI outside SERVICE is ignored.
- NMI path, independent of the mask, INT_FLAG and the FSM:
  - nmi_d registers NMI_IN every edge. A rising edge (NMI_IN=1, nmi_d=0) sets nmi_pend.
  - NMI = nmi_pend.
  - An edge with INT_ACK=1 while NMI=1 clears nmi_pend and is consumed by NMI only. The maskable FSM stays in PEND and INT is unaffected.
  - A new NMI edge arriving in the same cycle as the NMI ack: set wins, so NMI stays 1.
  - Further edges while NMI is pending merge into one.
- INT_ACK while in IDLE or SERVICE with NMI=0 is ignored.
- Widths: INT_ID is zero-extended from the winner index. Bits of IRQ at positions ≥ N_SRC do not exist.

Test Plan:
- Reset/idle: RST=1 for 2 edges with IRQ=8'hFF and NMI_IN=1 → INT=0, NMI=0, INT_ID=0, IN_SERVICE=0. After release with mask=0 → INT stays 0.
- Single request: mask=8'hFF, INT_FLAG=1, IRQ=8'h20 at edge t → INT=1, INT_ID=5 after t. INT_ACK at t+3 → INT=0, IN_SERVICE=1. EOI at t+6 → IN_SERVICE=0.
- Priority/mask: mask=8'hF0, IRQ=8'h5A → INT_ID=4. Then mask=8'hFF, IRQ=8'h5A after EOI → INT_ID=1.
- Gating: in PEND, drop INT_FLAG for 2 cycles → INT=0 for those cycles, INT_ID unchanged. Restore INT_FLAG → INT=1 again; IRQ dropping to 0 meanwhile does not clear INT.
- NMI priority: INT=1 in PEND, NMI_IN 0→1 → NMI=1 next edge. The first INT_ACK clears NMI only (INT stays 1, state PEND). A second INT_ACK → SERVICE.
- Boundaries: EOI and IRQ=8'h01 in the same cycle → INT=0 for one cycle, INT=1 the following edge. RST during SERVICE → IN_SERVICE=0, INT=0, mask=0.

Source files
------------

// File: rtl/interrupt_controller.sv
// Maskable + non-maskable interrupt source for the CPU: masks and prioritises
// level requests, drives INT/NMI and tracks the ACK/EOI handshake.
module interrupt_controller #(
   parameter int N_SRC = 8,
   parameter int ID_W  = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_SRC-1:0] IRQ,
   input  logic             NMI_IN,
   input  logic             MASK_WE,
   input  logic [N_SRC-1:0] MASK_DATA,
   input  logic             INT_FLAG,
   input  logic             INT_ACK,
   input  logic             EOI,
   output logic             INT,
   output logic             NMI,
   output logic [ID_W-1:0]  INT_ID,
   output logic             IN_SERVICE
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      SERVICE = 2'd2
   } stateT;

   stateT            state_q, state_d;
   logic [N_SRC-1:0] mask_q;
   logic [N_SRC-1:0] req;
   logic             reqAny;
   logic [ID_W-1:0]  winner;
   logic             intReq_q, intReq_d;
   logic [ID_W-1:0]  intId_q, intId_d;
   logic             inService_q, inService_d;
   logic             nmiDly_q;
   logic             nmiPend_q, nmiPend_d;
   logic             nmiRise;

   assign req    = IRQ & mask_q;
   assign reqAny = |req;

   // Scan from the top down so the lowest set index wins.
   always_comb begin
      winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) winner = ID_W'(i);
      end
   end

   // An ACK while NMI is pending belongs to the NMI, so the FSM must not see it.
   assign nmiRise = NMI_IN & ~nmiDly_q;

   always_comb begin
      nmiPend_d = nmiPend_q;
      if (INT_ACK && nmiPend_q) nmiPend_d = 1'b0;
      if (nmiRise)              nmiPend_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (INT_FLAG && reqAny)       state_d = PEND;
         PEND:    if (INT_ACK && !nmiPend_q)    state_d = SERVICE;
         SERVICE: if (EOI)                      state_d = IDLE;
         default:                               state_d = IDLE;
      endcase
   end

   always_comb begin
      intReq_d    = 1'b0;
      intId_d     = intId_q;
      inService_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (INT_FLAG && reqAny) begin
               intReq_d = 1'b1;
               intId_d  = winner;
            end
         end
         PEND: begin
            if (INT_ACK && !nmiPend_q) inService_d = 1'b1;
            else                       intReq_d    = INT_FLAG;
         end
         SERVICE: inService_d = ~EOI;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         intReq_q    <= 1'b0;
         intId_q     <= '0;
         inService_q <= 1'b0;
         nmiDly_q    <= 1'b0;
         nmiPend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         if (MASK_WE) mask_q <= MASK_DATA;
         intReq_q    <= intReq_d;
         intId_q     <= intId_d;
         inService_q <= inService_d;
         nmiDly_q    <= NMI_IN;
         nmiPend_q   <= nmiPend_d;
      end
   end

   assign INT        = intReq_q;
   assign NMI        = nmiPend_q;
   assign INT_ID     = intId_q;
   assign IN_SERVICE = inService_q;

endmodule
